// File: rtl/ahbl_wait_sram.sv
// AHB-Lite responder backed by a small register-file memory, with fixed or LFSR-driven wait
// states and a two-cycle ERROR response for an address window or oversize transfers.
module ahbl_wait_sram #(
  parameter int unsigned       W_ADDR     = 32,
  parameter int unsigned       W_DATA     = 32,
  parameter int unsigned       DEPTH      = 8,
  parameter bit                RANDOM     = 1'b0,
  parameter int unsigned       FIXED_WAIT = 0,
  parameter int unsigned       W_WAIT     = 2,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
  parameter logic [W_ADDR-1:0] ERR_ADDR   = '0,
  parameter logic [W_ADDR-1:0] ERR_MASK   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata
);

  localparam int unsigned N_BYTES  = W_DATA / 8;
  localparam int unsigned W_OFF    = $clog2(N_BYTES);
  localparam int unsigned W_IDX    = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE = 3'(W_OFF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dphase_q, dphase_d;
  logic             dwrite_q, dwrite_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic [W_OFF-1:0] off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             hready_q, hready_d;
  logic             hresp_q, hresp_d;
  logic [W_DATA-1:0] mem_q [DEPTH];

  logic             accept;
  logic             win_err;
  logic             size_err;
  logic             err_xfer;
  logic             final_cycle;
  logic             wr_en;
  logic [3:0]       wait_cnt;
  logic [15:0]      lfsr_next;
  logic [N_BYTES-1:0] be;

  logic unused;
  assign unused = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0]};

  assign accept      = ahbls_hready & ahbls_htrans[1];
  assign win_err     = (ERR_MASK != '0) && ((ahbls_haddr & ERR_MASK) == ERR_ADDR);
  assign size_err    = ahbls_hsize > MAX_SIZE;
  assign err_xfer    = win_err | size_err;
  // A pending OKAY data phase sitting in S_IDLE is in its final cycle.
  assign final_cycle = (state_q == S_IDLE) & dphase_q;
  assign wr_en       = final_cycle & dwrite_q;
  assign lfsr_next   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    if (RANDOM) begin
      wait_cnt = 4'(lfsr_q[W_WAIT-1:0]);
    end else begin
      wait_cnt = 4'(FIXED_WAIT);
    end
  end

  // Lane b is enabled when it falls in the same size-aligned block as the latched offset.
  always_comb begin
    be = '0;
    for (int unsigned b = 0; b < N_BYTES; b++) begin
      be[b] = ((W_OFF'(b) >> size_q) == (off_q >> size_q));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dphase_d = dphase_q;
    dwrite_d = dwrite_q;
    idx_d    = idx_q;
    off_d    = off_q;
    size_d   = size_q;
    lfsr_d   = lfsr_q;

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d  = S_IDLE;
        dphase_d = 1'b0;
      end
    endcase

    if (accept) begin
      idx_d    = ahbls_haddr[W_OFF +: W_IDX];
      off_d    = ahbls_haddr[W_OFF-1:0];
      size_d   = ahbls_hsize;
      dwrite_d = ahbls_hwrite;
      if (err_xfer) begin
        state_d  = S_ERR1;
        dphase_d = 1'b0;
      end else begin
        lfsr_d   = lfsr_next;
        dphase_d = 1'b1;
        if (wait_cnt != 4'd0) begin
          state_d = S_WAIT;
          cnt_d   = wait_cnt;
        end else begin
          state_d = S_IDLE;
        end
      end
    end

    hready_d = (state_d != S_WAIT) && (state_d != S_ERR1);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dphase_q <= 1'b0;
      dwrite_q <= 1'b0;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      dwrite_q <= dwrite_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      lfsr_q   <= lfsr_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < N_BYTES; b++) begin
        if (be[b]) begin
          mem_q[idx_q][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
        end
      end
    end
  end

  assign ahbls_hready_resp = hready_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = (final_cycle && !dwrite_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahbl_wait_sram.sv
// Scoreboard bench for ahbl_wait_sram: three instances (zero-wait with error window, three-wait,
// LFSR-random waits) each driven as the only slave on its bus.
module tb_ahbl_wait_sram;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hready_resp [3];
  logic        hresp [3];
  logic [31:0] haddr [3];
  logic        hwrite [3];
  logic [1:0]  htrans [3];
  logic [2:0]  hsize [3];
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   pending [3];
  int   waits [3];
  logic lo_or [3];
  logic lo_and [3];

  always #5 clk = ~clk;

  ahbl_wait_sram #(.ERR_ADDR(32'h80), .ERR_MASK(32'h80)) u0 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready_resp[0]),
    .ahbls_hready_resp(hready_resp[0]), .ahbls_hresp(hresp[0]), .ahbls_haddr(haddr[0]),
    .ahbls_hwrite(hwrite[0]), .ahbls_htrans(htrans[0]), .ahbls_hsize(hsize[0]),
    .ahbls_hburst(3'b000), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata[0]), .ahbls_hrdata(hrdata[0])
  );

  ahbl_wait_sram #(.FIXED_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready_resp[1]),
    .ahbls_hready_resp(hready_resp[1]), .ahbls_hresp(hresp[1]), .ahbls_haddr(haddr[1]),
    .ahbls_hwrite(hwrite[1]), .ahbls_htrans(htrans[1]), .ahbls_hsize(hsize[1]),
    .ahbls_hburst(3'b000), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata[1]), .ahbls_hrdata(hrdata[1])
  );

  ahbl_wait_sram #(.RANDOM(1'b1), .W_WAIT(2), .LFSR_SEED(16'hACE1), .ERR_ADDR(32'h80),
                   .ERR_MASK(32'h80)) ur (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready_resp[2]),
    .ahbls_hready_resp(hready_resp[2]), .ahbls_hresp(hresp[2]), .ahbls_haddr(haddr[2]),
    .ahbls_hwrite(hwrite[2]), .ahbls_htrans(htrans[2]), .ahbls_hsize(hsize[2]),
    .ahbls_hburst(3'b000), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata[2]), .ahbls_hrdata(hrdata[2])
  );

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  task automatic complete(input int d);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_completion dut%0d: got a data phase, expected none", d);
    end else begin
      e = exp_q.pop_front();
      check("dut_id", d, 64'(d), 64'(e.dut));
      check("wait_count", d, 64'(waits[d]), 64'(e.waits));
      check("hresp_final", d, 64'(hresp[d]), 64'(e.err));
      check("hrdata", d, 64'(hrdata[d]), 64'(e.rdata));
      if (waits[d] != 0) begin
        check("hresp_stall", d, 64'(e.err ? lo_and[d] : lo_or[d]), 64'(e.err));
      end
    end
  endtask

  // Monitor: samples at negedge, tracks each bus's data phase and pops on completion.
  initial begin
    for (int d = 0; d < 3; d++) pending[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          pending[d] = 1'b0;
        end else begin
          if (pending[d]) begin
            if (!hready_resp[d]) begin
              waits[d]++;
              lo_or[d]  = lo_or[d] | hresp[d];
              lo_and[d] = lo_and[d] & hresp[d];
            end else begin
              complete(d);
            end
          end else begin
            check("idle_outputs", d, {30'b0, hready_resp[d], hresp[d], hrdata[d]},
                  {30'b0, 1'b1, 1'b0, 32'h0});
          end
          if (hready_resp[d]) begin
            pending[d] = htrans[d][1];
            waits[d]   = 0;
            lo_or[d]   = 1'b0;
            lo_and[d]  = 1'b1;
          end
        end
      end
    end
  end

  // Present an address phase, hold it until accepted, then drive its write data.
  task automatic issue(input int d, input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [31:0] wdata, input logic [31:0] erd,
                       input logic eerr, input int ewait, input bit push = 1'b1);
    exp_t e;
    int   n;
    e.dut   = 2'(d);
    e.rdata = erd;
    e.err   = eerr;
    e.waits = 5'(ewait);
    if (push) exp_q.push_back(e);
    haddr[d]  = addr;
    hwrite[d] = wr;
    hsize[d]  = size;
    htrans[d] = 2'b10;
    n = 0;
    @(negedge clk);
    while (!hready_resp[d] && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (n >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got no hready, expected hready within 64 cycles", d);
    end
    @(posedge clk);
    #1;
    hwdata[d] = wdata;
    htrans[d] = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [15:0] lfsr;

  initial begin
    for (int d = 0; d < 3; d++) begin
      haddr[d]  = '0;
      hwrite[d] = 1'b0;
      htrans[d] = 2'b00;
      hsize[d]  = 3'd2;
      hwdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_state", d, {30'b0, hready_resp[d], hresp[d], hrdata[d]},
            {30'b0, 1'b1, 1'b0, 32'h0});
    end
    @(posedge clk);
    #1;

    // Zero-wait: write then pipelined read-after-write
    issue(0, 32'h4, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    issue(0, 32'h4, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    // Byte and halfword lane writes
    issue(0, 32'h8, 1'b1, 3'd2, 32'h11223344, 32'h0, 1'b0, 0);
    issue(0, 32'hA, 1'b1, 3'd0, 32'h00AA0000, 32'h0, 1'b0, 0);
    issue(0, 32'h8, 1'b0, 3'd2, 32'h0, 32'h11AA3344, 1'b0, 0);
    issue(0, 32'hC, 1'b1, 3'd2, 32'h55667788, 32'h0, 1'b0, 0);
    issue(0, 32'hE, 1'b1, 3'd1, 32'hBEEF0000, 32'h0, 1'b0, 0);
    issue(0, 32'hC, 1'b0, 3'd2, 32'h0, 32'hBEEF7788, 1'b0, 0);
    issue(0, 32'hC, 1'b1, 3'd1, 32'h1234CAFE, 32'h0, 1'b0, 0);
    issue(0, 32'hC, 1'b0, 3'd2, 32'h0, 32'hBEEFCAFE, 1'b0, 0);
    // Error window write leaves aliased word 1 untouched; oversize transfer errors
    issue(0, 32'h84, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    issue(0, 32'h4, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    issue(0, 32'h10, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 1);
    issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 0);
    drain();

    // Fixed three-wait read of zeroed memory
    issue(1, 32'h0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 3);
    drain();

    // LFSR-driven waits, with error transfers that must not advance the LFSR
    lfsr = 16'hACE1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6 || i == 13) issue(2, 32'h80, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1);
      issue(2, 32'(i * 4), 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, int'(lfsr[1:0]));
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    drain();

    // Reset during the second wait cycle of a write drops it
    issue(1, 32'h0, 1'b1, 3'd2, 32'h12345678, 32'h0, 1'b0, 3, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 1, {30'b0, hready_resp[1], hresp[1], hrdata[1]},
          {30'b0, 1'b1, 1'b0, 32'h0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 32'h0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 3);
    issue(1, 32'h0, 1'b1, 3'd2, 32'hA5A5A5A5, 32'h0, 1'b0, 3);
    issue(1, 32'h0, 1'b0, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
